// File: rtl/tx_responder.sv
// -----------------------------------------------------------------------------
// tx_responder
//
// Purpose:
//   Responder side of a request/acknowledge transfer handshake. An accepted
//   request runs through a preparation phase (busy), a data phase of TX_LEN
//   acknowledged beats (ack) and a one-cycle completion pulse (endtx). The
//   FSM then waits for the requester to drop req, so a held request cannot
//   start a second transfer. A request that arrives while the sink is not
//   ready is rejected with a one-cycle retry pulse. Rejections are counted
//   in a saturating counter that clears when a transfer completes.
//
// Parameters:
//   BUSY_CYC  busy-phase length in cycles (1..15)
//   TX_LEN    number of ack beats per transfer (1..15)
//
// Ports:
//   clk        in   sole clock, rising edge
//   rst        in   asynchronous active-high reset
//   req        in   level-sensitive transfer request
//   sink_rdy   in   sink can accept a transfer (looked at only in IDLE)
//   ack        out  data-beat acknowledge, high while in XFER
//   retry      out  one-cycle reject pulse
//   busy       out  high while in BUSY
//   endtx      out  one-cycle end-of-transfer pulse
//   retry_cnt  out  saturating count of retries since the last completion
//
// All outputs are flops loaded from a decode of the next state, so each
// output is high exactly in the cycles the FSM spends in its state.
// -----------------------------------------------------------------------------
module tx_responder #(
  parameter int unsigned BUSY_CYC = 2,
  parameter int unsigned TX_LEN   = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req,
  input  logic       sink_rdy,
  output logic       ack,
  output logic       retry,
  output logic       busy,
  output logic       endtx,
  output logic [7:0] retry_cnt
);

  // FSM encoding
  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_BUSY   = 3'd1;
  localparam logic [2:0] S_XFER   = 3'd2;
  localparam logic [2:0] S_RETRY  = 3'd3;
  localparam logic [2:0] S_END    = 3'd4;
  localparam logic [2:0] S_WAITLO = 3'd5;

  // Counters are loaded with length-1 on state entry and the state is left
  // on the edge where they read zero, giving exactly N cycles in the state.
  localparam logic [3:0] BUSY_LOAD = 4'(BUSY_CYC - 1);
  localparam logic [3:0] BEAT_LOAD = 4'(TX_LEN - 1);

  logic [2:0] state_q,     state_d;
  logic [3:0] busy_cnt_q,  busy_cnt_d;
  logic [3:0] beat_cnt_q,  beat_cnt_d;
  logic [7:0] retry_cnt_q, retry_cnt_d;
  logic       ack_q,       ack_d;
  logic       retry_q,     retry_d;
  logic       busy_q,      busy_d;
  logic       endtx_q,     endtx_d;

  // Next-state, counter and retry-count logic
  always_comb begin
    state_d     = state_q;
    busy_cnt_d  = busy_cnt_q;
    beat_cnt_d  = beat_cnt_q;
    retry_cnt_d = retry_cnt_q;
    case (state_q)
      S_IDLE: begin
        if (req == 1'b1) begin
          if (sink_rdy == 1'b1) begin
            state_d    = S_BUSY;
            busy_cnt_d = BUSY_LOAD;
          end else begin
            state_d = S_RETRY;
            // Saturate rather than wrap so a long reject storm stays visible
            if (retry_cnt_q != 8'hFF) begin
              retry_cnt_d = retry_cnt_q + 8'd1;
            end else begin
              retry_cnt_d = retry_cnt_q;
            end
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_BUSY: begin
        // req and sink_rdy are deliberately not looked at here
        if (busy_cnt_q == 4'd0) begin
          state_d    = S_XFER;
          beat_cnt_d = BEAT_LOAD;
        end else begin
          busy_cnt_d = busy_cnt_q - 4'd1;
        end
      end
      S_XFER: begin
        // Completing the last beat wins over a simultaneous req drop
        if (beat_cnt_q == 4'd0) begin
          state_d     = S_END;
          retry_cnt_d = 8'd0;
        end else if (req == 1'b0) begin
          state_d    = S_IDLE;
          beat_cnt_d = 4'd0;
        end else begin
          beat_cnt_d = beat_cnt_q - 4'd1;
        end
      end
      S_RETRY: begin
        state_d = S_IDLE;
      end
      S_END: begin
        state_d = S_WAITLO;
      end
      S_WAITLO: begin
        if (req == 1'b0) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_WAITLO;
        end
      end
      default: begin
        // Unreachable encodings recover to a quiet IDLE
        state_d    = S_IDLE;
        busy_cnt_d = 4'd0;
        beat_cnt_d = 4'd0;
      end
    endcase
  end

  // Moore output decode from the next state; flopped below
  always_comb begin
    ack_d   = (state_d == S_XFER);
    retry_d = (state_d == S_RETRY);
    busy_d  = (state_d == S_BUSY);
    endtx_d = (state_d == S_END);
  end

  // State, counter and output registers with asynchronous reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      busy_cnt_q  <= 4'd0;
      beat_cnt_q  <= 4'd0;
      retry_cnt_q <= 8'd0;
      ack_q       <= 1'b0;
      retry_q     <= 1'b0;
      busy_q      <= 1'b0;
      endtx_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      busy_cnt_q  <= busy_cnt_d;
      beat_cnt_q  <= beat_cnt_d;
      retry_cnt_q <= retry_cnt_d;
      ack_q       <= ack_d;
      retry_q     <= retry_d;
      busy_q      <= busy_d;
      endtx_q     <= endtx_d;
    end
  end

  assign ack       = ack_q;
  assign retry     = retry_q;
  assign busy      = busy_q;
  assign endtx     = endtx_q;
  assign retry_cnt = retry_cnt_q;

endmodule

// File: tb/tb_tx_responder.sv
// -----------------------------------------------------------------------------
// tb_tx_responder
//
// Self-checking bench for tx_responder with default parameters
// (BUSY_CYC=2, TX_LEN=4). Inputs change on the falling edge; outputs are
// sampled 1 time unit after the rising edge that consumed those inputs.
// -----------------------------------------------------------------------------
module tb_tx_responder;

  logic       clk;
  logic       rst;
  logic       req;
  logic       sink_rdy;
  logic       ack;
  logic       retry;
  logic       busy;
  logic       endtx;
  logic [7:0] retry_cnt;

  int n_cmp;
  int n_err;

  typedef struct packed {
    logic       req;
    logic       rdy;
    logic       ack;
    logic       retry;
    logic       busy;
    logic       endtx;
    logic [7:0] cnt;
  } vec_t;

  vec_t vecs[$];

  tx_responder #(.BUSY_CYC(2), .TX_LEN(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .sink_rdy  (sink_rdy),
    .ack       (ack),
    .retry     (retry),
    .busy      (busy),
    .endtx     (endtx),
    .retry_cnt (retry_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic add(input logic r, input logic s, input logic a, input logic rt,
                     input logic b, input logic e, input logic [7:0] c);
    vec_t v;
    v.req = r; v.rdy = s; v.ack = a; v.retry = rt; v.busy = b; v.endtx = e; v.cnt = c;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_all(input string name, input logic a, input logic rt,
                         input logic b, input logic e, input logic [7:0] c);
    chk({name, ".out"}, {4'd0, ack, retry, busy, endtx}, {4'd0, a, rt, b, e});
    chk({name, ".cnt"}, retry_cnt, c);
  endtask

  // Apply inputs on the falling edge, then sample after the next rising edge
  task automatic step(input logic r, input logic s);
    @(negedge clk);
    req      = r;
    sink_rdy = s;
    @(posedge clk);
    #1;
  endtask

  task automatic onehot_chk(input string name);
    chk(name, 8'(int'(ack) + int'(retry) + int'(busy) + int'(endtx) > 1), 8'd0);
  endtask

  initial begin
    int cyc;
    logic seen;
    n_cmp    = 0;
    n_err    = 0;
    rst      = 1'b1;
    req      = 1'b0;
    sink_rdy = 1'b0;

    // ---------------- reset state ----------------
    #2;
    chk_all("reset_async", 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      req      = 1'($urandom_range(1, 0));
      sink_rdy = 1'($urandom_range(1, 0));
      @(posedge clk);
      #1;
      chk_all("reset_rand", 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
    end
    @(negedge clk);
    req = 1'b0;
    rst = 1'b0;

    // ---------------- directed vector table ----------------
    // nominal: busy 1-2, ack 3-6, endtx 7, quiet while req held, then idle
    add(1,1, 0,0,1,0, 8'd0); add(1,1, 0,0,1,0, 8'd0);
    add(1,1, 1,0,0,0, 8'd0); add(1,1, 1,0,0,0, 8'd0);
    add(1,1, 1,0,0,0, 8'd0); add(1,1, 1,0,0,0, 8'd0);
    add(1,1, 0,0,0,1, 8'd0); add(1,1, 0,0,0,0, 8'd0);
    add(1,1, 0,0,0,0, 8'd0); add(0,1, 0,0,0,0, 8'd0);
    add(0,1, 0,0,0,0, 8'd0);
    // retries every 2nd cycle while sink not ready
    add(1,0, 0,1,0,0, 8'd1); add(1,0, 0,0,0,0, 8'd1);
    add(1,0, 0,1,0,0, 8'd2); add(1,0, 0,0,0,0, 8'd2);
    add(1,0, 0,1,0,0, 8'd3); add(1,0, 0,0,0,0, 8'd3);
    // accepted; sink_rdy wiggles during busy/xfer with no effect
    add(1,1, 0,0,1,0, 8'd3); add(1,0, 0,0,1,0, 8'd3);
    add(1,0, 1,0,0,0, 8'd3); add(1,1, 1,0,0,0, 8'd3);
    add(1,0, 1,0,0,0, 8'd3); add(1,0, 1,0,0,0, 8'd3);
    add(1,0, 0,0,0,1, 8'd0); add(1,0, 0,0,0,0, 8'd0);
    add(0,0, 0,0,0,0, 8'd0);
    // abort: one retry, then req dropped during the 2nd ack beat
    add(1,0, 0,1,0,0, 8'd1); add(1,1, 0,0,0,0, 8'd1);
    add(1,1, 0,0,1,0, 8'd1); add(1,1, 0,0,1,0, 8'd1);
    add(1,1, 1,0,0,0, 8'd1); add(1,1, 1,0,0,0, 8'd1);
    add(0,1, 0,0,0,0, 8'd1); add(0,1, 0,0,0,0, 8'd1);
    // new request accepted; req dropped on the last-beat edge still completes
    add(1,1, 0,0,1,0, 8'd1); add(1,1, 0,0,1,0, 8'd1);
    add(1,1, 1,0,0,0, 8'd1); add(1,1, 1,0,0,0, 8'd1);
    add(1,1, 1,0,0,0, 8'd1); add(1,1, 1,0,0,0, 8'd1);
    add(0,1, 0,0,0,1, 8'd0); add(0,1, 0,0,0,0, 8'd0);
    add(0,1, 0,0,0,0, 8'd0);

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].req, vecs[i].rdy);
      chk_all($sformatf("vec%0d", i), vecs[i].ack, vecs[i].retry, vecs[i].busy,
              vecs[i].endtx, vecs[i].cnt);
      onehot_chk($sformatf("onehot%0d", i));
    end

    // ---------------- async reset during XFER ----------------
    step(1'b1, 1'b1); step(1'b1, 1'b1); step(1'b1, 1'b1);
    chk("xfer_before_rst.ack", {7'd0, ack}, 8'd1);
    #2;
    rst = 1'b1;
    #1;
    chk_all("rst_mid_xfer", 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
    @(negedge clk);
    req = 1'b0;
    rst = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step(1'b0, 1'b1);
      if (endtx == 1'b1) seen = 1'b1;
    end
    chk("no_endtx_after_rst", {7'd0, seen}, 8'd0);

    // ---------------- saturation ----------------
    for (int i = 0; i < 300; i++) begin
      step(1'b1, 1'b0);
      chk("sat.retry", {7'd0, retry}, 8'd1);
      step(1'b1, 1'b0);
    end
    chk("sat.cnt", retry_cnt, 8'd255);
    step(1'b1, 1'b0);
    chk("sat.hold", retry_cnt, 8'd255);
    step(1'b0, 1'b0);
    // complete a transfer and find endtx within a bounded window
    step(1'b1, 1'b1);
    chk("sat.busy", {7'd0, busy}, 8'd1);
    cyc = 1;
    while (endtx !== 1'b1 && cyc < 20) begin
      step(1'b1, 1'b1);
      cyc++;
    end
    chk("sat.endtx_cycle", 8'(cyc), 8'd7);
    chk("sat.clear", retry_cnt, 8'd0);
    step(1'b0, 1'b1);
    step(1'b0, 1'b1);
    chk_all("final_idle", 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/tx_responder.md
TX_RESPONDER -- requirements
Module: tx_responder

Interface
REQ-001 Parameter BUSY_CYC, default 2, busy-phase length in cycles, legal range 1..15.
REQ-002 Parameter TX_LEN, default 4, ack-phase length in beats, legal range 1..15.
REQ-003 clk  input  1  sole clock; all state changes on its rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 req  input  1  transfer request from the requester, level-sensitive.
REQ-006 sink_rdy  input  1  downstream sink can accept a transfer; sampled only in IDLE.
REQ-007 ack  output  1  data-beat acknowledge, high during XFER.
REQ-008 retry  output  1  one-cycle reject pulse; the requester must retry.
REQ-009 busy  output  1  responder preparing; high during BUSY.
REQ-010 endtx  output  1  one-cycle end-of-transfer pulse.
REQ-011 retry_cnt  output  8  count of retries since the last completed transfer, saturating.

Function
REQ-012 The FSM shall have states IDLE, BUSY, XFER, RETRY, END and WAITLO.
REQ-013 All outputs shall be registered and Moore-decoded, so each asserts in the cycle after the edge that enters its state.
REQ-014 IDLE: req=1 and sink_rdy=1 -> BUSY; req=1 and sink_rdy=0 -> RETRY; req=0 -> stay.
REQ-015 RETRY: retry=1 for exactly one cycle -> IDLE, so a held req with sink_rdy=0 yields a retry pulse every 2nd cycle.
REQ-016 BUSY: busy=1 for exactly BUSY_CYC cycles, counted by a 4-bit down-counter -> XFER; req is ignored in BUSY.
REQ-017 XFER: ack=1 for TX_LEN cycles via a 4-bit beat counter; after the last beat -> END.
REQ-018 req=0 sampled in XFER -> abort to IDLE: ack low from the next cycle, endtx not asserted, retry_cnt unchanged.
REQ-019 req=0 sampled on the edge completing the last beat -> END; completion takes priority over abort.
REQ-020 END: endtx=1 for exactly one cycle -> WAITLO.
REQ-021 WAITLO: all handshake outputs low; stay until req=0 is sampled, then -> IDLE, so a lingering req never retriggers a transfer.
REQ-022 At most one of ack, retry, busy, endtx shall be high in any cycle.
REQ-023 retry_cnt shall increment by 1 on each entry to RETRY, saturate at 255 (no wrap), and clear to 0 on entry to END.
REQ-024 A changing sink_rdy outside IDLE shall have no effect.
REQ-025 Latency: req sampled high in IDLE with sink_rdy=1 -> busy in the next cycle, first ack BUSY_CYC cycles later, endtx BUSY_CYC+TX_LEN+1 cycles after the sampling edge.

Reset
REQ-026 rst=1 shall immediately, without waiting for clk, force state IDLE, ack=retry=busy=endtx=0, retry_cnt=0, and both counters to 0.
REQ-027 Reset asserted mid-operation in any state shall abandon the transfer with no endtx pulse.
REQ-028 After rst deasserts, the first rising edge shall evaluate IDLE transitions normally.

Verification
REQ-029 Reset: rst pulsed with random inputs -> all outputs 0, retry_cnt=0.
REQ-030 Nominal (defaults): req=1 and sink_rdy=1 held from edge 1 -> busy in cycles 1-2, ack in cycles 3-6, endtx in cycle 7, then all outputs low while req=1; req=0 -> IDLE.
REQ-031 Retry: sink_rdy=0 with req=1 for 6 cycles -> retry in cycles 1, 3, 5 and retry_cnt=3; sink_rdy=1 -> nominal sequence, then retry_cnt=0 in the cycle endtx is high.
REQ-032 Abort: req dropped during the 2nd ack beat -> ack low in the next cycle, no endtx, retry_cnt unchanged, and a new req is accepted from IDLE.
REQ-033 Async reset: rst raised between clock edges during XFER -> ack falls before the next edge; no endtx ever follows.
REQ-034 Saturation: 300 retries -> retry_cnt holds 255; a completed transfer -> 0.
